ro_buffer: RTL and testbench

RO_BUFFER -- requirements
Module: ro_buffer

---
 rtl/ro_buffer.sv | 179 +++++++++++++++++
 tb/tb_ro_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_buffer.sv
// Reorder buffer: allocates entries in program order, collects results
// from the ALU and load/store broadcast buses, and commits one finished
// entry per cycle from the head. A branch whose resolved next PC differs
// from its prediction flushes the whole buffer and redirects fetch.
//
// Handshakes: valid_from_issuer, alu_valid and lsb_valid are one-cycle
// qualifiers with no ready return. The issuer must watch full_to_issuer
// and stop issuing, and each bus pulse writes its entry exactly once.
// Allocation into a completely full buffer is dropped. All commit, store
// and flush outputs are single-cycle registered pulses.
module ro_buffer #(
    parameter int ROB_ID_WIDTH = 4,
    parameter int FULL_MARGIN  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    valid_from_issuer,
    input  logic [1:0]              signal_from_issuer,
    input  logic [4:0]              rd_from_issuer,
    input  logic [31:0]             pc_from_issuer,
    input  logic [31:0]             next_pc_from_issuer,
    output logic [ROB_ID_WIDTH-1:0] dest_to_issuer,
    output logic                    full_to_issuer,
    input  logic [ROB_ID_WIDTH-1:0] qj_from_issuer,
    input  logic [ROB_ID_WIDTH-1:0] qk_from_issuer,
    output logic                    valid_of_vj_to_issuer,
    output logic [31:0]             vj_to_issuer,
    output logic                    valid_of_vk_to_issuer,
    output logic [31:0]             vk_to_issuer,
    input  logic                    alu_valid,
    input  logic [ROB_ID_WIDTH-1:0] alu_dest,
    input  logic [31:0]             alu_value,
    input  logic [31:0]             alu_next_pc,
    input  logic                    lsb_valid,
    input  logic [ROB_ID_WIDTH-1:0] lsb_dest,
    input  logic [31:0]             lsb_value,
    output logic                    commit_valid_to_reg_file,
    output logic [4:0]              commit_rd_to_reg_file,
    output logic [ROB_ID_WIDTH-1:0] commit_dest_to_reg_file,
    output logic [31:0]             commit_value_to_reg_file,
    output logic                    store_commit_to_ls_buffer,
    output logic [ROB_ID_WIDTH-1:0] store_dest_to_ls_buffer,
    output logic                    reset_to_rob_bus,
    output logic [31:0]             target_pc_to_inst_fetcher
);
    localparam int N = (1 << ROB_ID_WIDTH) - 1;
    localparam logic [ROB_ID_WIDTH-1:0] ID_ONE  = ROB_ID_WIDTH'(1);
    localparam logic [ROB_ID_WIDTH-1:0] ID_LAST = ROB_ID_WIDTH'(N);
    localparam logic [1:0] KIND_STORE  = 2'd2;
    localparam logic [1:0] KIND_BRANCH = 2'd3;

    // Entry 0 exists only so IDs index directly; it is never allocated,
    // so its busy bit stays 0 and writes aimed at ID 0 fall away.
    logic        ent_busy  [0:N];
    logic        ent_ready [0:N];
    logic [1:0]  ent_kind  [0:N];
    logic [4:0]  ent_rd    [0:N];
    logic [31:0] ent_pnpc  [0:N];
    logic [31:0] ent_value [0:N];
    logic [31:0] ent_anpc  [0:N];

    logic [ROB_ID_WIDTH-1:0] head;
    logic [ROB_ID_WIDTH-1:0] tail;
    logic [ROB_ID_WIDTH-1:0] count;

    logic alloc_req;
    logic do_alloc;
    logic commit_fire;
    logic mispredict;

    function automatic logic [ROB_ID_WIDTH-1:0] next_id(input logic [ROB_ID_WIDTH-1:0] id);
        return (id == ID_LAST) ? ID_ONE : id + ID_ONE;
    endfunction

    // Operand lookup with same-cycle bus bypass; the ALU bus has priority.
    function automatic logic [32:0] lookup(input logic [ROB_ID_WIDTH-1:0] q);
        logic [32:0] r;
        r = 33'd0;
        if (q != '0) begin
            if (alu_valid && alu_dest == q)
                r = {1'b1, alu_value};
            else if (lsb_valid && lsb_dest == q)
                r = {1'b1, lsb_value};
            else if (ent_busy[q] && ent_ready[q])
                r = {1'b1, ent_value[q]};
        end
        return r;
    endfunction

    // The cycle after a flush the issuer's request is ignored outright.
    assign alloc_req   = valid_from_issuer && !reset_to_rob_bus;
    assign commit_fire = ent_busy[head] && ent_ready[head];
    assign mispredict  = commit_fire && ent_kind[head] == KIND_BRANCH &&
                         ent_anpc[head] != ent_pnpc[head];
    assign do_alloc    = alloc_req && !mispredict && count != ID_LAST;

    assign dest_to_issuer = alloc_req ? next_id(tail) : tail;
    assign full_to_issuer = (N - int'(count) - int'(alloc_req)) <= FULL_MARGIN;

    assign {valid_of_vj_to_issuer, vj_to_issuer} = lookup(qj_from_issuer);
    assign {valid_of_vk_to_issuer, vk_to_issuer} = lookup(qk_from_issuer);

    // Entry state, pointers and registered commit/flush pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= N; i++) ent_busy[i] <= 1'b0;
            head                      <= ID_ONE;
            tail                      <= ID_ONE;
            count                     <= '0;
            commit_valid_to_reg_file  <= 1'b0;
            commit_rd_to_reg_file     <= '0;
            commit_dest_to_reg_file   <= '0;
            commit_value_to_reg_file  <= '0;
            store_commit_to_ls_buffer <= 1'b0;
            store_dest_to_ls_buffer   <= '0;
            reset_to_rob_bus          <= 1'b0;
            target_pc_to_inst_fetcher <= '0;
        end else if (rdy) begin
            commit_valid_to_reg_file  <= 1'b0;
            store_commit_to_ls_buffer <= 1'b0;
            reset_to_rob_bus          <= 1'b0;

            // LSB first so that the ALU wins if both name the same entry.
            if (lsb_valid && ent_busy[lsb_dest]) begin
                ent_ready[lsb_dest] <= 1'b1;
                if (ent_kind[lsb_dest] != KIND_STORE)
                    ent_value[lsb_dest] <= lsb_value;
            end
            if (alu_valid && ent_busy[alu_dest]) begin
                ent_ready[alu_dest] <= 1'b1;
                ent_value[alu_dest] <= alu_value;
                ent_anpc[alu_dest]  <= alu_next_pc;
            end

            if (commit_fire) begin
                ent_busy[head] <= 1'b0;
                head           <= next_id(head);
                if (ent_kind[head] == KIND_STORE) begin
                    store_commit_to_ls_buffer <= 1'b1;
                    store_dest_to_ls_buffer   <= head;
                end else begin
                    commit_valid_to_reg_file <= 1'b1;
                    commit_rd_to_reg_file    <= ent_rd[head];
                    commit_dest_to_reg_file  <= head;
                    commit_value_to_reg_file <= ent_value[head];
                end
                if (mispredict) begin
                    reset_to_rob_bus          <= 1'b1;
                    target_pc_to_inst_fetcher <= ent_anpc[head];
                end
            end

            // The instruction PC seeds a fall-through actual next PC.
            if (do_alloc) begin
                ent_busy[tail]  <= 1'b1;
                ent_ready[tail] <= 1'b0;
                ent_kind[tail]  <= signal_from_issuer;
                ent_rd[tail]    <= rd_from_issuer;
                ent_pnpc[tail]  <= next_pc_from_issuer;
                ent_anpc[tail]  <= pc_from_issuer + 32'd4;
                tail            <= next_id(tail);
            end

            if (do_alloc && !commit_fire)
                count <= count + ID_ONE;
            else if (commit_fire && !do_alloc)
                count <= count - ID_ONE;

            // Flush overrides everything above at the same edge.
            if (mispredict) begin
                for (int i = 0; i <= N; i++) ent_busy[i] <= 1'b0;
                head  <= ID_ONE;
                tail  <= ID_ONE;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ro_buffer.sv
// Self-checking bench for ro_buffer: drives issue and writeback traffic,
// keeps a small per-entry model, and compares every commit or store
// release against an expected queue filled as results are driven.
module tb_ro_buffer;
    localparam logic [1:0] K_NORMAL = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_BRANCH = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        valid_from_issuer = 1'b0;
    logic [1:0]  signal_from_issuer = '0;
    logic [4:0]  rd_from_issuer = '0;
    logic [31:0] pc_from_issuer = '0;
    logic [31:0] next_pc_from_issuer = '0;
    logic [3:0]  dest_to_issuer;
    logic        full_to_issuer;
    logic [3:0]  qj_from_issuer = '0;
    logic [3:0]  qk_from_issuer = '0;
    logic        valid_of_vj_to_issuer, valid_of_vk_to_issuer;
    logic [31:0] vj_to_issuer, vk_to_issuer;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_dest = '0;
    logic [31:0] alu_value = '0;
    logic [31:0] alu_next_pc = '0;
    logic        lsb_valid = 1'b0;
    logic [3:0]  lsb_dest = '0;
    logic [31:0] lsb_value = '0;
    logic        commit_valid_to_reg_file;
    logic [4:0]  commit_rd_to_reg_file;
    logic [3:0]  commit_dest_to_reg_file;
    logic [31:0] commit_value_to_reg_file;
    logic        store_commit_to_ls_buffer;
    logic [3:0]  store_dest_to_ls_buffer;
    logic        reset_to_rob_bus;
    logic [31:0] target_pc_to_inst_fetcher;

    ro_buffer #(.ROB_ID_WIDTH(4), .FULL_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .valid_from_issuer(valid_from_issuer),
        .signal_from_issuer(signal_from_issuer),
        .rd_from_issuer(rd_from_issuer),
        .pc_from_issuer(pc_from_issuer),
        .next_pc_from_issuer(next_pc_from_issuer),
        .dest_to_issuer(dest_to_issuer),
        .full_to_issuer(full_to_issuer),
        .qj_from_issuer(qj_from_issuer),
        .qk_from_issuer(qk_from_issuer),
        .valid_of_vj_to_issuer(valid_of_vj_to_issuer),
        .vj_to_issuer(vj_to_issuer),
        .valid_of_vk_to_issuer(valid_of_vk_to_issuer),
        .vk_to_issuer(vk_to_issuer),
        .alu_valid(alu_valid), .alu_dest(alu_dest),
        .alu_value(alu_value), .alu_next_pc(alu_next_pc),
        .lsb_valid(lsb_valid), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
        .commit_valid_to_reg_file(commit_valid_to_reg_file),
        .commit_rd_to_reg_file(commit_rd_to_reg_file),
        .commit_dest_to_reg_file(commit_dest_to_reg_file),
        .commit_value_to_reg_file(commit_value_to_reg_file),
        .store_commit_to_ls_buffer(store_commit_to_ls_buffer),
        .store_dest_to_ls_buffer(store_dest_to_ls_buffer),
        .reset_to_rob_bus(reset_to_rob_bus),
        .target_pc_to_inst_fetcher(target_pc_to_inst_fetcher)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int n_checks = 0;
    int n_bad = 0;
    logic [41:0] exp_q[$];
    logic [1:0]  m_kind [0:15];
    logic [4:0]  m_rd   [0:15];
    logic [31:0] m_val  [0:15];
    logic [3:0]  m_tail = 4'd1;
    int prev_commit_cyc = 0;
    int last_commit_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] id);
        return (id == 4'd15) ? 4'd1 : id + 4'd1;
    endfunction

    // commit monitor: pops the expected queue on each commit/store pulse
    always @(negedge clk) begin
        logic [41:0] got;
        if (!rst && (commit_valid_to_reg_file || store_commit_to_ls_buffer)) begin
            if (store_commit_to_ls_buffer)
                got = {1'b1, 5'd0, store_dest_to_ls_buffer, 32'd0};
            else
                got = {1'b0, commit_rd_to_reg_file, commit_dest_to_reg_file, commit_value_to_reg_file};
            if (commit_valid_to_reg_file && store_commit_to_ls_buffer)
                check("dual_pulse", 64'(1), 64'(0));
            if (exp_q.size() == 0)
                check("unexpected_commit", 64'(got), 64'(0));
            else
                check("commit", 64'(got), 64'(exp_q.pop_front()));
            prev_commit_cyc = last_commit_cyc;
            last_commit_cyc = cyc;
        end
    end

    // driver tasks
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_tail = 4'd1;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] npc, input bit chk_full, input bit exp_full);
        #1;
        check("dest_idle", 64'(dest_to_issuer), 64'(m_tail));
        valid_from_issuer   = 1'b1;
        signal_from_issuer  = kind;
        rd_from_issuer      = rd;
        pc_from_issuer      = pc;
        next_pc_from_issuer = npc;
        #1;
        check("dest_issue", 64'(dest_to_issuer), 64'(nxt(m_tail)));
        if (chk_full) check("full", 64'(full_to_issuer), 64'(exp_full));
        m_kind[m_tail] = kind;
        m_rd[m_tail]   = rd;
        m_val[m_tail]  = 32'd0;
        @(posedge clk); #1;
        valid_from_issuer = 1'b0;
        m_tail = nxt(m_tail);
    endtask

    task automatic wb(input bit use_alu, input logic [3:0] aid, input logic [31:0] aval,
                      input logic [31:0] anpc, input bit use_lsb, input logic [3:0] lid,
                      input logic [31:0] lval);
        alu_valid = use_alu; alu_dest = aid; alu_value = aval; alu_next_pc = anpc;
        lsb_valid = use_lsb; lsb_dest = lid; lsb_value = lval;
        if (use_lsb && m_kind[lid] != K_STORE) m_val[lid] = lval;
        if (use_alu) m_val[aid] = aval;
        @(posedge clk); #1;
        alu_valid = 1'b0;
        lsb_valid = 1'b0;
    endtask

    task automatic expect_commit(input logic [3:0] id);
        if (m_kind[id] == K_STORE) exp_q.push_back({1'b1, 5'd0, id, 32'd0});
        else                       exp_q.push_back({1'b0, m_rd[id], id, m_val[id]});
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    // main sequence
    initial begin
        logic [31:0] v;
        logic [3:0]  ids[6];

        // reset state
        @(posedge clk); #1;
        do_reset();
        #1;
        check("rst_dest", 64'(dest_to_issuer), 64'(1));
        check("rst_full", 64'(full_to_issuer), 64'(0));
        check("rst_commit", 64'(commit_valid_to_reg_file), 64'(0));
        check("rst_store", 64'(store_commit_to_ls_buffer), 64'(0));
        check("rst_flush", 64'(reset_to_rob_bus), 64'(0));
        check("rst_target", 64'(target_pc_to_inst_fetcher), 64'(0));
        qj_from_issuer = 4'd1; #1;
        check("rst_lookup", 64'(valid_of_vj_to_issuer), 64'(0));

        // reset in the middle of a pending commit
        issue(K_NORMAL, 5'd4, 32'h40, 32'h44, 1'b0, 1'b0);
        wb(1'b1, 4'd1, 32'h1234, 32'h44, 1'b0, 4'd0, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_tail = 4'd1;
        check("midrst_commit", 64'(commit_valid_to_reg_file), 64'(0));
        check("midrst_dest", 64'(dest_to_issuer), 64'(1));
        check("midrst_lookup", 64'(valid_of_vj_to_issuer), 64'(0));
        repeat (3) @(posedge clk);
        #1;

        // single normal instruction
        issue(K_NORMAL, 5'd5, 32'h0, 32'h4, 1'b1, 1'b0);
        wb(1'b1, 4'd1, 32'h2A, 32'h4, 1'b0, 4'd0, 32'd0);
        expect_commit(4'd1);
        drain();

        // 13 back-to-back, full threshold, then wrap
        do_reset();
        for (int i = 0; i < 13; i++)
            issue(K_NORMAL, 5'(i + 1), 32'h1000 + 32'(i * 4), 32'h1004 + 32'(i * 4), 1'b1, i >= 12);
        for (int i = 1; i <= 13; i += 2) begin
            v = $urandom;
            if (i + 1 <= 13) begin
                wb(1'b1, 4'(i), v, 32'd0, 1'b1, 4'(i + 1), $urandom);
                expect_commit(4'(i));
                expect_commit(4'(i + 1));
            end else begin
                wb(1'b1, 4'(i), v, 32'd0, 1'b0, 4'd0, 32'd0);
                expect_commit(4'(i));
            end
        end
        drain();
        for (int i = 0; i < 6; i++) begin
            ids[i] = m_tail;
            issue(i[0] ? K_LOAD : K_NORMAL, 5'($urandom_range(0, 31)), 32'h2000, 32'h2004, 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            wb(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, ids[i], $urandom);
            expect_commit(ids[i]);
        end
        drain();

        // lookup from storage and from same-cycle bus
        do_reset();
        for (int i = 0; i < 4; i++) issue(K_NORMAL, 5'(i + 10), 32'h0, 32'h4, 1'b0, 1'b0);
        wb(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd3, 32'h10);
        qj_from_issuer = 4'd3; qk_from_issuer = 4'd2; #1;
        check("vj_valid", 64'(valid_of_vj_to_issuer), 64'(1));
        check("vj_value", 64'(vj_to_issuer), 64'(32'h10));
        check("vk_notready", 64'(valid_of_vk_to_issuer), 64'(0));
        qk_from_issuer = 4'd4;
        alu_valid = 1'b1; alu_dest = 4'd4; alu_value = 32'h20;
        lsb_valid = 1'b1; lsb_dest = 4'd4; lsb_value = 32'h99;
        #1;
        check("vk_bypass_valid", 64'(valid_of_vk_to_issuer), 64'(1));
        check("vk_bypass_value", 64'(vk_to_issuer), 64'(32'h20));
        m_val[4] = 32'h20;
        @(posedge clk); #1;
        alu_valid = 1'b0; lsb_valid = 1'b0;
        qj_from_issuer = 4'd0; #1;
        check("vk_stored", 64'(vk_to_issuer), 64'(32'h20));
        check("vj_id0", 64'(valid_of_vj_to_issuer), 64'(0));
        wb(1'b1, 4'd1, 32'hA1, 32'd0, 1'b1, 4'd2, 32'hB2);
        for (int i = 1; i <= 4; i++) expect_commit(4'(i));
        drain();

        // branch mispredict flush
        do_reset();
        issue(K_BRANCH, 5'd7, 32'h100, 32'h104, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) issue(K_NORMAL, 5'(i + 1), 32'h104, 32'h108, 1'b0, 1'b0);
        wb(1'b1, 4'd1, 32'h104, 32'h200, 1'b0, 4'd0, 32'd0);
        expect_commit(4'd1);
        valid_from_issuer = 1'b1; signal_from_issuer = K_NORMAL;
        @(posedge clk); #1;
        check("flush_pulse", 64'(reset_to_rob_bus), 64'(1));
        check("flush_target", 64'(target_pc_to_inst_fetcher), 64'(32'h200));
        check("flush_dest", 64'(dest_to_issuer), 64'(1));
        check("flush_full", 64'(full_to_issuer), 64'(0));
        @(posedge clk); #1;
        valid_from_issuer = 1'b0; #1;
        check("flush_pulse_end", 64'(reset_to_rob_bus), 64'(0));
        check("after_flush_dest", 64'(dest_to_issuer), 64'(1));
        m_tail = 4'd1;
        wb(1'b1, 4'd2, 32'h55, 32'd0, 1'b1, 4'd3, 32'h66);
        qj_from_issuer = 4'd2; #1;
        check("flushed_lookup", 64'(valid_of_vj_to_issuer), 64'(0));
        issue(K_NORMAL, 5'd9, 32'h200, 32'h204, 1'b1, 1'b0);
        wb(1'b1, 4'd1, 32'h77, 32'd0, 1'b0, 4'd0, 32'd0);
        expect_commit(4'd1);
        drain();
        issue(K_BRANCH, 5'd8, 32'h204, 32'h300, 1'b0, 1'b0);
        wb(1'b1, 4'd2, 32'h208, 32'h300, 1'b0, 4'd0, 32'd0);
        expect_commit(4'd2);
        drain();
        check("good_branch_tail", 64'(dest_to_issuer), 64'(3));

        // in-order store then load
        do_reset();
        issue(K_STORE, 5'd0, 32'h0, 32'h4, 1'b0, 1'b0);
        issue(K_LOAD, 5'd9, 32'h4, 32'h8, 1'b0, 1'b0);
        wb(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        wb(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd1, 32'hDEAD);
        expect_commit(4'd1);
        expect_commit(4'd2);
        drain();
        check("load_after_store", 64'(last_commit_cyc - prev_commit_cyc), 64'(1));

        // rdy low holds a ready head
        do_reset();
        issue(K_NORMAL, 5'd3, 32'h0, 32'h4, 1'b0, 1'b0);
        wb(1'b1, 4'd1, 32'h77, 32'd0, 1'b0, 4'd0, 32'd0);
        rdy = 1'b0;
        expect_commit(4'd1);
        qj_from_issuer = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_commit", 64'(commit_valid_to_reg_file), 64'(0));
            check("stall_dest", 64'(dest_to_issuer), 64'(2));
            check("stall_lookup", 64'(valid_of_vj_to_issuer), 64'(1));
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        check("resume_commit", 64'(commit_valid_to_reg_file), 64'(1));
        check("resume_dest", 64'(commit_dest_to_reg_file), 64'(1));
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("final_queue", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
